// File: rtl/primogen_pkg.sv
// Shared types for the primogen arbiter: FSM state encoding and default result width.
package primogen_pkg;

  localparam int PRIMOGEN_W = 16;

  typedef enum logic [2:0] {
    ST_RESTART   = 3'd0,
    ST_IDLE      = 3'd1,
    ST_GO        = 3'd2,
    ST_WAIT_FALL = 3'd3,
    ST_WAIT_RISE = 3'd4,
    ST_DONE      = 3'd5
  } primogen_arb_state_t;

endpackage

// File: rtl/primogen_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr wins; ptr_nxt points past it.
module primogen_rr_arb #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   ptr_nxt
);

  int idx;

  always_comb begin
    win     = '0;
    ptr_nxt = ptr;
    idx     = 0;
    if (en) begin
      // Scan from farthest to nearest so the nearest requester overwrites last.
      for (int i = NREQ - 1; i >= 0; i--) begin
        idx = (int'(ptr) + i) % NREQ;
        if (((req >> idx) & NREQ'(1)) != '0) begin
          win     = NREQ'(1) << idx;
          ptr_nxt = PW'((idx + 1) % NREQ);
        end
      end
    end
  end

endmodule

// File: rtl/primogen_arb.sv
// Round-robin sharing of one primogen generator between NREQ clients, including generator restart.
// Optional watchdog on the wait states: define PRIMOGEN_ARB_TIMEOUT_EN.
//
// state        | meaning
// RESTART      | gen_rst high for one cycle, sequence restarts at 1
// IDLE         | waiting for a request while the generator is ready
// GO           | gen_go pulse to the generator
// WAIT_FALL    | waiting for gen_ready to drop
// WAIT_RISE    | waiting for gen_ready to return, then capture gen_res
// DONE         | done/err pulse to the granted client
module primogen_arb
  import primogen_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = PRIMOGEN_W,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic [NREQ-1:0] err,
  output logic [W-1:0]    res,
  output logic            busy,
  output logic            gen_go,
  output logic            gen_rst,
  input  logic            gen_ready,
  input  logic            gen_error,
  input  logic [W-1:0]    gen_res
);

  localparam int PW = $clog2(NREQ);

  primogen_arb_state_t state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       nptr_q, nptr_d;
  logic [W-1:0]        res_q, res_d;
  logic                err_q, err_d;
  logic [NREQ-1:0]     win;
  logic [PW-1:0]       win_ptr_nxt;
  logic                waiting;
  logic                wd_expired;

  assign waiting = (state_q == ST_WAIT_FALL) || (state_q == ST_WAIT_RISE);

  primogen_rr_arb #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .en      ((state_q == ST_IDLE) && gen_ready),
    .win     (win),
    .ptr_nxt (win_ptr_nxt)
  );

`ifdef PRIMOGEN_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = CW'(TIMEOUT - 1);
    if (waiting && (wd_q != '0)) wd_d = wd_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wd_q <= CW'(TIMEOUT - 1);
    else      wd_q <= wd_d;
  end

  assign wd_expired = waiting && (wd_q == '0);
`else
  // Watchdog compiled out: never expires.
  assign wd_expired = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    nptr_d  = nptr_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      ST_RESTART: state_d = ST_IDLE;
      ST_IDLE: begin
        if (win != '0) begin
          gnt_d   = win;
          nptr_d  = win_ptr_nxt;
          state_d = ST_GO;
        end
      end
      ST_GO: state_d = ST_WAIT_FALL;
      ST_WAIT_FALL: begin
        if (!gen_ready) begin
          state_d = ST_WAIT_RISE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WAIT_RISE: begin
        if (gen_ready) begin
          res_d   = gen_res;
          err_d   = gen_error;
          state_d = ST_DONE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ptr_d   = nptr_q;
        gnt_d   = '0;
        err_d   = 1'b0;
        state_d = err_q ? ST_RESTART : ST_IDLE;
      end
      default: state_d = ST_RESTART;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RESTART;
      gnt_q   <= '0;
      ptr_q   <= '0;
      nptr_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      nptr_q  <= nptr_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = (state_q == ST_DONE) ? gnt_q : '0;
  assign err     = ((state_q == ST_DONE) && err_q) ? gnt_q : '0;
  assign res     = res_q;
  assign busy    = (state_q != ST_IDLE);
  assign gen_go  = (state_q == ST_GO);
  assign gen_rst = (state_q == ST_RESTART);

endmodule

// File: tb/tb_primogen_arb.sv
// Scoreboard bench for primogen_arb with a behavioural primogen model; covers the watchdog when
// PRIMOGEN_ARB_TIMEOUT_EN is defined.
module tb_primogen_arb;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] gnt, done, err;
  logic [W-1:0]    res;
  logic            busy, gen_go, gen_rst;
  logic            gen_ready = 1'b1;
  logic            gen_error = 1'b0;
  logic [W-1:0]    gen_res   = 16'd1;

  always #5 clk = ~clk;

  primogen_arb #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .res       (res),
    .busy      (busy),
    .gen_go    (gen_go),
    .gen_rst   (gen_rst),
    .gen_ready (gen_ready),
    .gen_error (gen_error),
    .gen_res   (gen_res)
  );

  typedef struct {
    logic [NREQ-1:0] who;
    logic [W-1:0]    val;
    logic            e;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   tests = 0;
  int   fails = 0;
  int   busy_len = 2;
  int   bcnt = 0;
  bit   inject_err = 1'b0;
  bit   stuck = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] next_prime(input logic [W-1:0] p);
    bit ok;
    for (int n = int'(p) + 1; n < 65536; n++) begin
      ok = 1'b1;
      for (int d = 2; d * d <= n; d++) if (n % d == 0) ok = 1'b0;
      if (ok) return W'(n);
    end
    return '0;
  endfunction

  function automatic exp_t mk(input logic [NREQ-1:0] who, input logic [W-1:0] val, input logic e);
    exp_t x;
    x.who = who;
    x.val = val;
    x.e   = e;
    return x;
  endfunction

  // Generator model, updated mid-cycle so the DUT sees it as registered inputs.
  always @(negedge clk) begin
    if (gen_rst) begin
      gen_ready = 1'b1;
      gen_res   = 16'd1;
      gen_error = 1'b0;
      bcnt      = 0;
    end else if (gen_go && gen_ready) begin
      gen_ready = 1'b0;
      gen_error = 1'b0;
      bcnt      = busy_len;
    end else if (!gen_ready && !stuck) begin
      if (bcnt > 1) bcnt--;
      else begin
        gen_res   = next_prime(gen_res);
        gen_error = inject_err;
        gen_ready = 1'b1;
      end
    end
  end

  // Monitor: every done pulse is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && (done != '0)) begin
      if (sb.size() == 0) check("unexpected_done", 32'(done), 32'd0);
      else begin
        m_e = sb.pop_front();
        check("done_who", 32'(done), 32'(m_e.who));
        check("gnt_match", 32'(gnt), 32'(m_e.who));
        check("res", 32'(res), 32'(m_e.val));
        check("err", 32'(err), m_e.e ? 32'(m_e.who) : 32'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_dones(input int n);
    int got = 0;
    int k = 0;
    while (got < n && k < 400) begin
      @(negedge clk);
      k++;
      if (done != '0) got++;
    end
    if (got < n) check("done_timeout", 32'(got), 32'(n));
  endtask

  task automatic wait_go();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!gen_go && k < 100);
    if (!gen_go) check("go_timeout", 32'(gen_go), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {gen_rst, busy, gen_go, gnt, done, err, res},
          {1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int k;
    int lowc;
    cyc(2);
    check_reset_outputs("reset_outputs");
    rst = 1'b1;
    cyc(1);
    check("restart_then_idle", 32'(busy), 32'd0);

    // Single requester: 2, 3, 5, 7
    sb.push_back(mk(4'b0001, 16'd2, 1'b0));
    sb.push_back(mk(4'b0001, 16'd3, 1'b0));
    sb.push_back(mk(4'b0001, 16'd5, 1'b0));
    sb.push_back(mk(4'b0001, 16'd7, 1'b0));
    req = 4'b0001;
    wait_dones(4);
    req = '0;
    cyc(4);
    check("idle_after_single", 32'(busy), 32'd0);

    // All requesting after a fresh reset: rotation 0,1,2,3,0
    do_reset();
    sb.push_back(mk(4'b0001, 16'd2, 1'b0));
    sb.push_back(mk(4'b0010, 16'd3, 1'b0));
    sb.push_back(mk(4'b0100, 16'd5, 1'b0));
    sb.push_back(mk(4'b1000, 16'd7, 1'b0));
    sb.push_back(mk(4'b0001, 16'd11, 1'b0));
    req = 4'b1111;
    wait_dones(5);
    req = '0;
    cyc(3);

    // req[2] dropped one cycle after grant still completes
    sb.push_back(mk(4'b0100, 16'd13, 1'b0));
    req = 4'b0100;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!gnt[2] && k < 100);
    check("gnt2_seen", 32'(gnt), 32'h4);
    @(negedge clk);
    req = '0;
    wait_dones(1);
    cyc(3);

    // Generator error: err with done, restart next cycle, sequence back to 2
    inject_err = 1'b1;
    sb.push_back(mk(4'b0001, 16'd17, 1'b1));
    sb.push_back(mk(4'b0001, 16'd2, 1'b0));
    req = 4'b0001;
    wait_dones(1);
    inject_err = 1'b0;
    cyc(1);
    check("gen_rst_after_err", 32'(gen_rst), 32'd1);
    wait_dones(1);
    req = '0;
    cyc(3);

    // Reset during WAIT_RISE aborts silently
    busy_len = 5;
    req = 4'b0001;
    wait_go();
    cyc(2);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort_reset_outputs");
    busy_len = 2;
    sb.push_back(mk(4'b0001, 16'd2, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    wait_dones(1);
    req = '0;
    cyc(3);

    // Generator that never becomes ready again
    stuck = 1'b1;
    req = 4'b0001;
    wait_go();
    req = '0;
`ifdef PRIMOGEN_ARB_TIMEOUT_EN
    sb.push_back(mk(4'b0001, 16'd2, 1'b1));
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done == '0 && k < 60);
    check("timeout_latency", 32'(k), 32'd17);
    stuck = 1'b0;
    cyc(1);
    check("gen_rst_after_timeout", 32'(gen_rst), 32'd1);
`else
    lowc = 0;
    repeat (100) begin
      @(negedge clk);
      if (!busy) lowc++;
    end
    check("busy_held_no_watchdog", 32'(lowc), 32'd0);
    rst = 1'b0;
    stuck = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`endif
    sb.push_back(mk(4'b0001, 16'd2, 1'b0));
    req = 4'b0001;
    wait_dones(1);
    req = '0;
    cyc(5);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
